// File: rtl/vc_pkg.sv
// Shared types and sizing helpers for the vc memory-port arbiter.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package vc_pkg;

    // Which cache currently owns the external memory port
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Arbiter sequencing: decide, request, stream beats, one idle turnaround
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        XFER_I = 3'd3,
        XFER_D = 3'd4,
        TURN   = 3'd5
    } state_t;

    localparam int I_BEATS_DEF = 4;
    localparam int D_BEATS_DEF = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Beat-counter width; floor of 1 bit so a single-beat burst still has a register
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = max_int(a, b);
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_W = cnt_width(I_BEATS_DEF, D_BEATS_DEF);

endpackage

// File: rtl/vc_beat_counter.sv
// Counts qualified burst beats and flags the final one against a selectable limit.
// Latency: o_last is combinational with the beat; count clears on the edge after it.
// Backpressure: none; advances only on i_beat, which the owner of the port qualifies.
module vc_beat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_beat,
    input  logic [W-1:0] i_limit,
    output logic         o_last
);

    logic [W-1:0] r_count;

    assign o_last = i_beat && (r_count == i_limit);

    // Advance on each qualified beat, wrap to zero on the final beat of the burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_beat) begin
            if (o_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vc_mem_arbiter.sv
// Shares one external memory port between I-cache fills and D-cache reads/writes.
// Latency: request seen in IDLE -> m_req next cycle; x_last -> next m_req at least 2 cycles.
// Backpressure: requester holds req until x_last; beats are paced entirely by the memory port.
module vc_mem_arbiter
    import vc_pkg::*;
#(
    parameter int PA      = 24,
    parameter int I_BEATS = I_BEATS_DEF,
    parameter int D_BEATS = D_BEATS_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    // I-cache line fill
    input  logic          i_req,
    input  logic [PA-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic          i_last,
    // D-cache fill / write-back
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [PA-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic          d_wready,
    output logic          d_last,
    output logic [15:0]   rdata,
    // Memory port
    output logic          m_req,
    output logic          m_wr,
    output logic [PA-1:0] m_addr,
    output logic [15:0]   m_wdata,
    input  logic          m_ack,
    input  logic          m_rvalid,
    input  logic          m_wready,
    input  logic [15:0]   m_rdata
);

    localparam int CW = cnt_width(I_BEATS, D_BEATS);
    localparam logic [CW-1:0] I_LIM = CW'(I_BEATS - 1);
    localparam logic [CW-1:0] D_LIM = CW'(D_BEATS - 1);

    state_t        r_state;
    owner_t        r_owner;
    logic          r_fair;
    logic          r_m_req;
    logic          r_m_wr;
    logic [PA-1:0] r_m_addr;

    logic          w_xfer_i;
    logic          w_xfer_d;
    logic          w_beat;
    logic          w_last;
    logic [CW-1:0] w_limit;

    assign w_xfer_i = (r_state == XFER_I);
    assign w_xfer_d = (r_state == XFER_D);

    // A beat only counts in the owner's transfer state; writes pace on wready, reads on rvalid
    assign w_beat  = (w_xfer_i && m_rvalid)
                   || (w_xfer_d && (r_m_wr ? m_wready : m_rvalid));
    assign w_limit = w_xfer_d ? D_LIM : I_LIM;

    vc_beat_counter #(
        .W (CW)
    ) u_beat_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_beat  (w_beat),
        .i_limit (w_limit),
        .o_last  (w_last)
    );

    // Arbitration and port sequencing; port request fields are captured on entry to REQ_x
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_owner  <= OWN_NONE;
            r_fair   <= 1'b0;
            r_m_req  <= 1'b0;
            r_m_wr   <= 1'b0;
            r_m_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // D first, unless I already lost a round to D
                    if (d_req && !(i_req && r_fair)) begin
                        r_state  <= REQ_D;
                        r_owner  <= OWN_D;
                        r_m_req  <= 1'b1;
                        r_m_wr   <= d_wr;
                        r_m_addr <= d_addr;
                    end else if (i_req) begin
                        r_state  <= REQ_I;
                        r_owner  <= OWN_I;
                        r_m_req  <= 1'b1;
                        r_m_wr   <= 1'b0;
                        r_m_addr <= i_addr;
                    end
                end
                REQ_I: begin
                    if (m_ack) begin
                        r_state <= XFER_I;
                        r_m_req <= 1'b0;
                        r_fair  <= 1'b0;
                    end
                end
                REQ_D: begin
                    if (m_ack) begin
                        r_state <= XFER_D;
                        r_m_req <= 1'b0;
                        if (i_req) begin
                            r_fair <= 1'b1;
                        end
                    end
                end
                XFER_I, XFER_D: begin
                    // Requester dropping req early does not cut the burst short
                    if (w_last) begin
                        r_state  <= TURN;
                        r_owner  <= OWN_NONE;
                        r_m_wr   <= 1'b0;
                        r_m_addr <= '0;
                    end
                end
                TURN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign m_req   = r_m_req;
    assign m_wr    = r_m_wr;
    assign m_addr  = r_m_addr;
    assign m_wdata = (r_owner == OWN_D) ? d_wdata : 16'h0000;

    // Handshakes are only forwarded in the matching state, so stray strobes never leak
    assign i_gnt    = (r_state == REQ_I) && m_ack;
    assign d_gnt    = (r_state == REQ_D) && m_ack;
    assign i_rvalid = w_xfer_i && m_rvalid;
    assign d_rvalid = w_xfer_d && !r_m_wr && m_rvalid;
    assign d_wready = w_xfer_d && r_m_wr && m_wready;
    assign i_last   = w_xfer_i && w_last;
    assign d_last   = w_xfer_d && w_last;
    assign rdata    = (w_xfer_i || w_xfer_d) ? m_rdata : 16'h0000;

endmodule

// File: tb/tb_vc_mem_arbiter.sv
module tb_vc_mem_arbiter;

    localparam int PA = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [PA-1:0] i_addr;
    logic          i_gnt, i_rvalid, i_last;
    logic          d_req, d_wr;
    logic [PA-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic          d_gnt, d_rvalid, d_wready, d_last;
    logic [15:0]   rdata;
    logic          m_req, m_wr;
    logic [PA-1:0] m_addr;
    logic [15:0]   m_wdata;
    logic          m_ack, m_rvalid, m_wready;
    logic [15:0]   m_rdata;

    int errors = 0;
    int checks = 0;

    vc_mem_arbiter #(.PA(PA), .I_BEATS(4), .D_BEATS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_rvalid (i_rvalid),
        .i_last   (i_last),
        .d_req    (d_req),
        .d_wr     (d_wr),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_wready (d_wready),
        .d_last   (d_last),
        .rdata    (rdata),
        .m_req    (m_req),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rvalid (m_rvalid),
        .m_wready (m_wready),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".i_gnt"},    i_gnt,    0);
        check({tag, ".i_rvalid"}, i_rvalid, 0);
        check({tag, ".i_last"},   i_last,   0);
        check({tag, ".d_gnt"},    d_gnt,    0);
        check({tag, ".d_rvalid"}, d_rvalid, 0);
        check({tag, ".d_wready"}, d_wready, 0);
        check({tag, ".d_last"},   d_last,   0);
        check({tag, ".rdata"},    rdata,    0);
        check({tag, ".m_req"},    m_req,    0);
        check({tag, ".m_wr"},     m_wr,     0);
        check({tag, ".m_addr"},   m_addr,   0);
        check({tag, ".m_wdata"},  m_wdata,  0);
    endtask

    // One read transaction: wait for m_req, ack it, feed nbeats read beats
    task automatic run_txn(input bit is_d, input logic [PA-1:0] addr, input int nbeats,
                           input int exp_gap, input logic [15:0] base);
        int waited;
        waited = 0;
        while (m_req !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        if (exp_gap >= 0) check("req_gap", waited, exp_gap);
        else              check("req_seen", m_req, 1);
        check("txn.m_addr", m_addr, addr);
        check("txn.m_wr", m_wr, 0);
        m_ack = 1'b1;
        #1;
        check("txn.i_gnt", i_gnt, !is_d);
        check("txn.d_gnt", d_gnt, is_d);
        tick();
        m_ack = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            m_rvalid = 1'b1;
            m_rdata  = base + 16'(k);
            #1;
            check(is_d ? "txn.d_rvalid" : "txn.i_rvalid", is_d ? d_rvalid : i_rvalid, 1);
            check("txn.other_rvalid", is_d ? i_rvalid : d_rvalid, 0);
            check("txn.rdata", rdata, 32'(base) + k);
            check(is_d ? "txn.d_last" : "txn.i_last", is_d ? d_last : i_last, (k == nbeats - 1));
            tick();
        end
        m_rvalid = 1'b0;
        m_rdata  = 16'h0000;
    endtask

    initial begin
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = 16'h0000;
        m_ack = 1'b0; m_rvalid = 1'b0; m_wready = 1'b0; m_rdata = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Spurious beat in IDLE
        m_rvalid = 1'b1; m_rdata = 16'h5555;
        #1;
        check("idle_spur.i_rvalid", i_rvalid, 0);
        check("idle_spur.d_rvalid", d_rvalid, 0);
        check("idle_spur.rdata", rdata, 0);
        tick();
        m_rvalid = 1'b0; m_rdata = 16'h0000;

        // I-only fill
        i_req = 1'b1; i_addr = 24'h001230;
        #1;
        check("i1.m_req_idle", m_req, 0);
        tick();
        m_rvalid = 1'b1; m_rdata = 16'h5A5A;
        #1;
        check("i1.m_req", m_req, 1);
        check("i1.m_addr", m_addr, 24'h001230);
        check("i1.m_wr", m_wr, 0);
        check("i1.spur_i_rvalid", i_rvalid, 0);
        check("i1.i_gnt_early", i_gnt, 0);
        tick();
        m_rvalid = 1'b0; m_ack = 1'b1;
        #1;
        check("i1.i_gnt", i_gnt, 1);
        check("i1.d_gnt", d_gnt, 0);
        tick();
        m_ack = 1'b0;
        #1;
        check("i1.m_req_drop", m_req, 0);
        check("i1.i_gnt_pulse", i_gnt, 0);
        for (int k = 0; k < 4; k++) begin
            m_rvalid = 1'b1; m_rdata = 16'h00A0 + 16'(k);
            #1;
            check("i1.i_rvalid", i_rvalid, 1);
            check("i1.rdata", rdata, 32'h00A0 + k);
            check("i1.d_rvalid", d_rvalid, 0);
            check("i1.i_last", i_last, (k == 3));
            tick();
        end
        m_rvalid = 1'b0; m_rdata = 16'h0000; i_req = 1'b0;
        #1;
        check("i1.turn_m_req", m_req, 0);
        check("i1.turn_i_last", i_last, 0);
        tick();
        tick();
        check("i1.idle_m_req", m_req, 0);

        // D write burst
        d_req = 1'b1; d_wr = 1'b1; d_addr = 24'h800010; d_wdata = 16'h1111;
        tick();
        check("dw.m_req", m_req, 1);
        check("dw.m_wr", m_wr, 1);
        check("dw.m_addr", m_addr, 24'h800010);
        m_ack = 1'b1;
        #1;
        check("dw.d_gnt", d_gnt, 1);
        check("dw.i_gnt", i_gnt, 0);
        tick();
        m_ack = 1'b0; m_wready = 1'b1;
        #1;
        check("dw.b1_wready", d_wready, 1);
        check("dw.b1_wdata", m_wdata, 16'h1111);
        check("dw.b1_last", d_last, 0);
        tick();
        d_wdata = 16'h2222;
        #1;
        check("dw.b2_wready", d_wready, 1);
        check("dw.b2_wdata", m_wdata, 16'h2222);
        check("dw.b2_last", d_last, 1);
        tick();
        d_req = 1'b0; d_wr = 1'b0;
        #1;
        check("dw.turn_spur_wready", d_wready, 0);
        check("dw.turn_m_req", m_req, 0);
        check("dw.turn_m_wr", m_wr, 0);
        check("dw.turn_m_wdata", m_wdata, 0);
        check("dw.turn_d_last", d_last, 0);
        m_wready = 1'b0;
        tick();

        // Simultaneous requests, both then held: D, I, D, I, D, I
        i_req = 1'b1; i_addr = 24'h00ABC0;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 24'h400020;
        run_txn(1'b1, 24'h400020, 2, -1, 16'h00D0);
        run_txn(1'b0, 24'h00ABC0, 4,  2, 16'h00B0);
        run_txn(1'b1, 24'h400020, 2,  2, 16'h00D4);
        run_txn(1'b0, 24'h00ABC0, 4,  2, 16'h00B8);
        run_txn(1'b1, 24'h400020, 2,  2, 16'h00D8);
        run_txn(1'b0, 24'h00ABC0, 4,  2, 16'h00BC);
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();

        // Async reset during beat 2 of an I fill
        i_req = 1'b1; i_addr = 24'h002000;
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 16'h00C0;
        #1;
        check("rst.b1_i_rvalid", i_rvalid, 1);
        tick();
        m_rdata = 16'h00C1;
        #1;
        check("rst.b2_i_rvalid", i_rvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_rst");
        m_rvalid = 1'b0; m_rdata = 16'h0000; i_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // D read after reset: d_last on beat 2 shows the counter restarted at 0
        d_req = 1'b1; d_wr = 1'b0; d_addr = 24'h400040;
        run_txn(1'b1, 24'h400040, 2, -1, 16'h00E0);
        d_req = 1'b0;
        tick();
        tick();
        check("end.m_req", m_req, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
